// File: rtl/subtractor_operand_feeder.sv
// Operand feeder for the |A-B| subtractor: queues operand pairs, drives the
// start/done handshake one pair at a time and presents each magnitude on a
// valid/ready result port holding at most one pending result.
module subtractor_operand_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             sub_start,
  output logic [WIDTH-1:0] sub_data_A,
  output logic [WIDTH-1:0] sub_data_B,
  input  logic             sub_done,
  input  logic [WIDTH-1:0] sub_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] mem_A [DEPTH];
  logic [WIDTH-1:0] mem_B [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;
  logic capture;

  // Full flag ignores a same-cycle pop so in_ready never depends on sub_done.
  assign in_ready   = (count != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign sub_data_A = mem_A[rd_ptr];
  assign sub_data_B = mem_B[rd_ptr];
  assign busy       = (state != IDLE) || (count != '0);

  // FIFO storage: operand data is not reset, only the occupancy tracking is.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_A[wr_ptr] <= in_A;
      mem_B[wr_ptr] <= in_B;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Handshake state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, Moore start output, and the pop/capture strobes.
  always_comb begin
    state_nxt = state;
    sub_start = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // Only issue when the result slot is free (or freeing this cycle).
        if ((count != '0) && (!res_valid || res_ready)) state_nxt = ISSUE;
      end
      ISSUE: begin
        sub_start = 1'b1;
        // Subtractor loads the FIFO head on this edge; a done still low from
        // a job abandoned by reset simply stretches ISSUE.
        if (sub_done) begin
          pop       = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!sub_done) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sub_done) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-entry result slot; a capture on the transfer edge keeps valid high.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= sub_result;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
